lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
Load/store unit on the initiator side of the data-memory interface. It accepts one RV32 load or store per request from the execute/memory stage and checks its alignment. It drives a word-aligned request with a byte-lane mask and lane-replicated write data to a variable-latency data memory. For loads it extracts and sign- or zero-extends the returned word, and it stalls the pipeline until the access completes.

Parameters:
TIMEOUT, 16, max cycles mem_req may stay high without mem_ack before the access aborts with an error (≥1)
CNT_W, $clog2(TIMEOUT+1), width of the timeout counter

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  reset, asynchronous and active-high
rd_en  input  1  load request from pipeline, held until done
wr_en  input  1  store request from pipeline, held until done
func3  input  3  RV32 load/store func3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
addr  input  32  byte address from ALU
wdata  input  32  store data, in low bits, unshifted
rdata  output  32  formatted load result, valid when done=1
done  output  1  one-cycle pulse, access finished (ok or error)
err  output  1  valid with done: misaligned, illegal func3, rd_en&wr_en, or timeout
stall  output  1  freeze upstream pipeline
mem_req  output  1  memory request, registered
mem_we  output  1  1 = write
mem_addr  output  32  {addr[31:2],2'b00}
mem_mask  output  4  byte-lane write enables (bit i = byte i)
mem_wdata  output  32  lane-replicated store data
mem_ack  input  1  memory completes the current request this cycle
mem_rdata  input  32  read word, valid with mem_ack when mem_we=0

Behaviour:
- Reset (async): state=IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_mask=0, mem_wdata=0, rdata=0, done=0, err=0, cnt=0. Reset during BUSY drops mem_req immediately; the in-flight access is abandoned and no done pulse is issued.
- FSM states: IDLE, BUSY, DONE.
- IDLE with rd_en|wr_en:
  - Check the request.
  - Illegal if rd_en&wr_en, or the func3 does not match the direction (load: 000/001/010/100/101; store: 000/001/010).
  - Misaligned if halfword and addr[0]=1, or word and addr[1:0]!=0.
  - Illegal or misaligned: go to DONE with err latched to 1; mem_req is never asserted.
  - Otherwise: latch mem_we, mem_addr, mem_mask, mem_wdata, func3 and addr[1:0]; set mem_req=1 and cnt=0; go to BUSY.
- Mask and data for stores:
  - SB: mask = 1<<addr[1:0], wdata = {4{wdata[7:0]}}.
  - SH: mask = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{wdata[15:0]}}.
  - SW: mask = 4'b1111, wdata = wdata.
  - Loads drive mask = 0000.
- BUSY:
  - All mem_* outputs are held stable while mem_req=1.
  - On mem_ack: mem_req becomes 0; for a load, rdata takes the formatted value from mem_rdata; err=0; go to DONE.
  - Load formatting:
    - LB/LBU select byte addr[1:0]; LH/LHU select half addr[1].
    - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - Without ack: cnt++. When cnt==TIMEOUT-1 and no ack, mem_req becomes 0, err=1, go to DONE.
  - An ack in the same cycle as the timeout limit counts as success.
- DONE: done=1 for exactly one cycle, with err valid in that cycle; request inputs are ignored; go to IDLE.
- Output behaviour:
  - done/err are registered: done=1 only in DONE.
  - err holds its value until the next access is accepted.
  - rdata holds the last load result until the next successful load; stores and errors do not change it.
- stall = (state==IDLE & (rd_en|wr_en)) | (state==BUSY). It is 0 in DONE, so the pipeline advances in the done cycle.
- Latency with zero-wait memory (ack in the first mem_req cycle):
  - Accept at cycle 0; mem_req=1 and ack at cycle 1; done at cycle 2.
  - Stall lasts 2 cycles.
  - Each extra memory wait cycle adds 1.
- Error path: accept at cycle 0, done=1 and err=1 at cycle 1, stall lasts 1 cycle.
- Back-to-back requests: the next request is accepted in the IDLE cycle after DONE; no bubble beyond that is required.

Decomposition:
- lsu_pkg: func3 localparams (F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101) and the state enum typedef {IDLE, BUSY, DONE}.
- Sub-module lsu_align (combinational):
  - Store side: func3, addr[1:0], wdata -> mask, lane data, misalign.
  - Load side: func3, addr[1:0], mem_rdata -> formatted rdata.
  - Instantiated once; lsu_ctrl holds the FSM, timeout counter and registers.

Test Plan:
- SW addr=0x10, wdata=0xDEADBEEF, ack on the first mem_req cycle -> mem_addr=0x10, mask=1111, mem_wdata=0xDEADBEEF, mem_we=1, done at cycle 2, err=0, stall high for 2 cycles.
- SB addr=0x13, wdata=0x000000A5 -> mask=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x10. LB addr=0x13 with mem_rdata=0x80112233 -> rdata=0xFFFFFF80; LBU at the same address -> rdata=0x00000080.
- LH addr=0x22 with mem_rdata=0x9ABC1234 and ack after 3 wait cycles -> rdata=0xFFFF9ABC; mem_* stable throughout BUSY; done 5 cycles after accept.
- LW addr=0x06 -> no mem_req, done=1 and err=1 at cycle 1, rdata unchanged. SH addr=0x01 -> the same. rd_en=wr_en=1 -> the same.
- TIMEOUT=16, LW addr=0x40, mem_ack never asserted -> mem_req high for exactly 16 cycles, then done=1 and err=1.
- Assert rst during BUSY -> mem_req=0 in the same cycle (async), state IDLE, no done pulse. After release, a fresh SW completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32 func3 encodings and FSM states.
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store mask/replicated data/misalign check, and
// load byte/half extraction with sign or zero extension. No state, no backpressure.
module lsu_align import lsu_pkg::*; (
  input  logic [2:0]  st_func3,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_mask,
  output logic [31:0] st_lane_wdata,
  output logic        misalign,
  input  logic [2:0]  ld_func3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    misalign = 1'b0;
    case (st_func3[1:0])
      2'b01:   misalign = st_addr_lo[0];
      2'b10:   misalign = (st_addr_lo != 2'b00);
      default: misalign = 1'b0;
    endcase
  end

  always_comb begin
    st_mask       = 4'b1111;
    st_lane_wdata = st_wdata;
    case (st_func3)
      F3_B: begin
        st_mask       = 4'b0001 << st_addr_lo;
        st_lane_wdata = {4{st_wdata[7:0]}};
      end
      F3_H: begin
        st_mask       = st_addr_lo[1] ? 4'b1100 : 4'b0011;
        st_lane_wdata = {2{st_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign ld_byte = ld_word[{ld_addr_lo, 3'b000} +: 8];
  assign ld_half = ld_addr_lo[1] ? ld_word[31:16] : ld_word[15:0];

  always_comb begin
    ld_data = ld_word;
    case (ld_func3)
      F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data = {24'd0, ld_byte};
      F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_data = {16'd0, ld_half};
      default: ld_data = ld_word;
    endcase
  end
endmodule

// File: rtl/lsu_ctrl.sv
// RV32 load/store controller: one access per request, done 2 cycles after accept plus memory wait cycles.
// Stalls the pipeline while a request is pending; memory side waits on mem_ack with a timeout abort.
module lsu_ctrl import lsu_pkg::*; #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        err,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_mask,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        func3_q;
  logic [1:0]        addr_lo_q;
  logic [31:0]       rdata_q, mem_addr_q, mem_wdata_q;
  logic [3:0]        mem_mask_q;
  logic              done_q, err_q, mem_req_q, mem_we_q;

  logic [3:0]        st_mask;
  logic [31:0]       st_lane_wdata, ld_data;
  logic              misalign, illegal;

  lsu_align u_align (
    .st_func3      (func3),
    .st_addr_lo    (addr[1:0]),
    .st_wdata      (wdata),
    .st_mask       (st_mask),
    .st_lane_wdata (st_lane_wdata),
    .misalign      (misalign),
    .ld_func3      (func3_q),
    .ld_addr_lo    (addr_lo_q),
    .ld_word       (mem_rdata),
    .ld_data       (ld_data)
  );

  always_comb begin
    illegal = 1'b0;
    if (rd_en && wr_en)
      illegal = 1'b1;
    else if (wr_en)
      illegal = !(func3 inside {F3_B, F3_H, F3_W});
    else
      illegal = !(func3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  end

  assign cnt_d = cnt_q + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      func3_q     <= '0;
      addr_lo_q   <= '0;
      rdata_q     <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_mask_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (rd_en || wr_en) begin
            if (illegal || misalign) begin
              // Rejected requests never reach the memory side.
              state_q <= DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q     <= BUSY;
              err_q       <= 1'b0;
              mem_req_q   <= 1'b1;
              mem_we_q    <= wr_en;
              mem_addr_q  <= {addr[31:2], 2'b00};
              mem_mask_q  <= wr_en ? st_mask : 4'b0000;
              mem_wdata_q <= st_lane_wdata;
              func3_q     <= func3;
              addr_lo_q   <= addr[1:0];
              cnt_q       <= '0;
            end
          end
        end
        BUSY: begin
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            err_q     <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= DONE;
            if (!mem_we_q)
              rdata_q <= ld_data;
          end else if (cnt_q == CNT_MAX) begin
            mem_req_q <= 1'b0;
            err_q     <= 1'b1;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stall     = ((state_q == IDLE) && (rd_en || wr_en)) || (state_q == BUSY);
  assign rdata     = rdata_q;
  assign done      = done_q;
  assign err       = err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_mask  = mem_mask_q;
  assign mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed vector table, reset corner cases, and random accesses
// checked against an arithmetic reference model of the load/store rules.
module tb_lsu_ctrl;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en, wr_en, mem_ack;
  logic [2:0]  func3;
  logic [31:0] addr, wdata, mem_rdata;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic        done, err, stall, mem_req, mem_we;
  logic [3:0]  mem_mask;

  always #5 clk = ~clk;

  lsu_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .func3(func3),
    .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .err(err),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_mask(mem_mask), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Results of the most recent access.
  int          r_done, r_req, r_stall;
  logic        r_err, r_stable, r_we;
  logic [31:0] r_rdata, r_addr, r_wdata;
  logic [3:0]  r_mask;

  // Starts in the cycle after a posedge with the DUT idle; returns one cycle after done.
  // waits < 0 means the memory never acknowledges.
  task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int waits, input logic [31:0] rword);
    logic fin;
    r_done = -1; r_req = 0; r_stall = 0; r_err = 1'bx; r_stable = 1'b1;
    r_rdata = 'x; r_addr = 'x; r_wdata = 'x; r_mask = 'x; r_we = 1'bx;
    rd_en = rd; wr_en = wr; func3 = f3; addr = a; wdata = wd; mem_rdata = rword;
    fin = 1'b0;
    for (int c = 0; c < 100 && !fin; c++) begin
      @(negedge clk);
      if (stall) r_stall++;
      if (done) begin
        r_done = c; r_err = err; r_rdata = rdata; fin = 1'b1;
        rd_en = 1'b0; wr_en = 1'b0;
      end else if (mem_req) begin
        if (r_req == 0) begin
          r_addr = mem_addr; r_mask = mem_mask; r_wdata = mem_wdata; r_we = mem_we;
        end else if (mem_addr !== r_addr || mem_mask !== r_mask ||
                     mem_wdata !== r_wdata || mem_we !== r_we) begin
          r_stable = 1'b0;
        end
        mem_ack = (waits >= 0 && r_req == waits);
        r_req++;
      end
      @(posedge clk); #1;
      mem_ack = 1'b0;
    end
    rd_en = 1'b0; wr_en = 1'b0;
  endtask

  typedef struct {
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] a, wd;
    int          waits;
    logic [31:0] rword;
    logic        e_err;
    logic [31:0] e_rdata;
    int          e_done, e_req;
    logic [3:0]  e_mask;
    logic [31:0] e_wdata;
  } vec_t;

  function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd, input int waits,
                              input logic [31:0] rword, input logic e_err,
                              input logic [31:0] e_rdata, input int e_done, input int e_req,
                              input logic [3:0] e_mask, input logic [31:0] e_wdata);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.a = a; v.wd = wd; v.waits = waits;
    v.rword = rword; v.e_err = e_err; v.e_rdata = e_rdata; v.e_done = e_done;
    v.e_req = e_req; v.e_mask = e_mask; v.e_wdata = e_wdata;
    return v;
  endfunction

  vec_t vecs[15];

  initial begin
    vecs[0]  = mk(0, 1, 3'd2, 32'h10, 32'hDEADBEEF, 0, 0,             0, 32'h0,        2, 1, 4'hF, 32'hDEADBEEF);
    vecs[1]  = mk(0, 1, 3'd0, 32'h13, 32'h000000A5, 0, 0,             0, 32'h0,        2, 1, 4'h8, 32'hA5A5A5A5);
    vecs[2]  = mk(1, 0, 3'd0, 32'h13, 0, 0, 32'h80112233,             0, 32'hFFFFFF80, 2, 1, 4'h0, 0);
    vecs[3]  = mk(1, 0, 3'd4, 32'h13, 0, 0, 32'h80112233,             0, 32'h00000080, 2, 1, 4'h0, 0);
    vecs[4]  = mk(1, 0, 3'd1, 32'h22, 0, 3, 32'h9ABC1234,             0, 32'hFFFF9ABC, 5, 4, 4'h0, 0);
    vecs[5]  = mk(1, 0, 3'd2, 32'h06, 0, 0, 32'h55555555,             1, 32'hFFFF9ABC, 1, 0, 4'h0, 0);
    vecs[6]  = mk(0, 1, 3'd1, 32'h01, 32'h1234, 0, 0,                 1, 32'hFFFF9ABC, 1, 0, 4'h0, 0);
    vecs[7]  = mk(1, 1, 3'd2, 32'h20, 0, 0, 0,                        1, 32'hFFFF9ABC, 1, 0, 4'h0, 0);
    vecs[8]  = mk(1, 0, 3'd5, 32'h20, 0, 0, 32'h9ABC8765,             0, 32'h00008765, 2, 1, 4'h0, 0);
    vecs[9]  = mk(1, 0, 3'd2, 32'h44, 0, 1, 32'h12345678,             0, 32'h12345678, 3, 2, 4'h0, 0);
    vecs[10] = mk(0, 1, 3'd1, 32'h12, 32'h0000BEEF, 0, 0,             0, 32'h12345678, 2, 1, 4'hC, 32'hBEEFBEEF);
    vecs[11] = mk(0, 1, 3'd4, 32'h00, 32'h1, 0, 0,                    1, 32'h12345678, 1, 0, 4'h0, 0);
    vecs[12] = mk(1, 0, 3'd3, 32'h00, 0, 0, 0,                        1, 32'h12345678, 1, 0, 4'h0, 0);
    vecs[13] = mk(1, 0, 3'd2, 32'h40, 0, -1, 0,                       1, 32'h12345678, 1 + TIMEOUT, TIMEOUT, 4'h0, 0);
    vecs[14] = mk(1, 0, 3'd0, 32'h11, 0, 0, 32'h00007F00,             0, 32'h0000007F, 2, 1, 4'h0, 0);

    rst = 1'b1; rd_en = 0; wr_en = 0; func3 = 0; addr = 0; wdata = 0;
    mem_ack = 0; mem_rdata = 0;
    #1;
    chk("rst_mem_req", {31'd0, mem_req}, 0);
    chk("rst_mem_we", {31'd0, mem_we}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_mask", {28'd0, mem_mask}, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_err", {31'd0, err}, 0);
    chk("rst_stall", {31'd0, stall}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) begin
      run_op(vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].a, vecs[i].wd, vecs[i].waits, vecs[i].rword);
      chk($sformatf("v%0d_done_cycle", i), r_done, vecs[i].e_done);
      chk($sformatf("v%0d_err", i), {31'd0, r_err}, {31'd0, vecs[i].e_err});
      chk($sformatf("v%0d_rdata", i), r_rdata, vecs[i].e_rdata);
      chk($sformatf("v%0d_req_cycles", i), r_req, vecs[i].e_req);
      chk($sformatf("v%0d_stall_cycles", i), r_stall, vecs[i].e_done);
      chk($sformatf("v%0d_err_hold", i), {31'd0, err}, {31'd0, vecs[i].e_err});
      chk($sformatf("v%0d_done_one_cycle", i), {31'd0, done}, 0);
      if (vecs[i].e_req > 0) begin
        chk($sformatf("v%0d_mem_addr", i), r_addr, {vecs[i].a[31:2], 2'b00});
        chk($sformatf("v%0d_mem_we", i), {31'd0, r_we}, {31'd0, vecs[i].wr});
        chk($sformatf("v%0d_mem_mask", i), {28'd0, r_mask}, {28'd0, vecs[i].e_mask});
        chk($sformatf("v%0d_stable", i), {31'd0, r_stable}, 1);
        if (vecs[i].wr)
          chk($sformatf("v%0d_mem_wdata", i), r_wdata, vecs[i].e_wdata);
      end
    end

    // Reset in the middle of an access: request drops at once, no done pulse.
    rd_en = 1'b1; func3 = 3'd2; addr = 32'h80;
    @(posedge clk); #1;
    chk("rb_req_before", {31'd0, mem_req}, 1);
    #2 rst = 1'b1;
    #1;
    chk("rb_req_async", {31'd0, mem_req}, 0);
    chk("rb_done_async", {31'd0, done}, 0);
    rd_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("rb_no_done_%0d", k), {30'd0, done, mem_req}, 0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rb_idle_stall", {31'd0, stall}, 0);
    chk("rb_rdata_cleared", rdata, 0);
    run_op(0, 1, 3'd2, 32'h30, 32'h11223344, 0, 0);
    chk("rb_sw_done", r_done, 2);
    chk("rb_sw_err", {31'd0, r_err}, 0);
    chk("rb_sw_mask", {28'd0, r_mask}, 32'hF);
    chk("rb_sw_wdata", r_wdata, 32'h11223344);
    chk("rb_sw_addr", r_addr, 32'h30);

    // Random accesses against the reference model.
    begin
      logic [31:0] last_rdata;
      last_rdata = 32'h0;
      for (int n = 0; n < 150; n++) begin
        int kind, waits, size, off, e_done, e_req;
        logic rd, wr, illegal, misal, e_err;
        logic [2:0] f3;
        logic [31:0] a, wd, rword, e_wdata;
        logic [3:0] e_mask;
        longint v;
        kind  = int'($urandom_range(0, 9));
        rd    = (kind < 5) || (kind == 9);
        wr    = (kind >= 5);
        f3    = 3'($urandom_range(0, 7));
        a     = $urandom;
        wd    = $urandom;
        rword = $urandom;
        waits = ($urandom_range(0, 19) == 0) ? -1 : int'($urandom_range(0, 4));

        size    = 1 << (f3 % 4);
        off     = int'(a % 4);
        illegal = (rd && wr) || (wr && f3 > 2) || (rd && !wr && !(f3 inside {0, 1, 2, 4, 5}));
        misal   = !illegal && (a % size != 0);
        e_err   = illegal || misal || waits < 0;
        e_done  = (illegal || misal) ? 1 : (waits < 0 ? 1 + TIMEOUT : 2 + waits);
        e_req   = (illegal || misal) ? 0 : (waits < 0 ? TIMEOUT : waits + 1);
        e_mask  = 4'(((1 << size) - 1) << off);
        for (int b = 0; b < 4; b++)
          e_wdata[8*b +: 8] = 8'((wd >> (8 * (b % size))) & 32'hFF);
        if (rd && !e_err) begin
          v = longint'(rword) >> (8 * off);
          if (size < 4) begin
            v = v % (longint'(1) << (8 * size));
            if (f3 < 4 && v >= (longint'(1) << (8 * size - 1)))
              v = v - (longint'(1) << (8 * size));
          end
          last_rdata = 32'(v);
        end

        run_op(rd, wr, f3, a, wd, waits, rword);
        chk($sformatf("r%0d_done_cycle", n), r_done, e_done);
        chk($sformatf("r%0d_err", n), {31'd0, r_err}, {31'd0, e_err});
        chk($sformatf("r%0d_rdata", n), r_rdata, last_rdata);
        chk($sformatf("r%0d_req_cycles", n), r_req, e_req);
        if (e_req > 0) begin
          chk($sformatf("r%0d_mem_addr", n), r_addr, {a[31:2], 2'b00});
          chk($sformatf("r%0d_stable", n), {31'd0, r_stable}, 1);
          chk($sformatf("r%0d_mem_mask", n), {28'd0, r_mask}, wr ? {28'd0, e_mask} : 32'd0);
          if (wr)
            chk($sformatf("r%0d_mem_wdata", n), r_wdata, e_wdata);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
